alu_cmd_ctrl: RTL

Command sequencer that sits directly upstream of the ALU. It parses byte-wide command frames from the UART RX path, loads operands and function code, drives ALU_EN and holds it until the ALU reports OUT_VALID, then forwards the result byte to the TX FIFO. A bounded wait produces an error byte if the ALU never responds.

---
 rtl/alu_cmd_ctrl_if.sv | 29 ++
 rtl/alu_cmd_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl_if.sv
// Command-sequencer bus: RX bytes in, ALU operand/enable out, ALU result in, TX strobe out.
// master = environment (UART RX, ALU, TX FIFO); slave = the sequencer.
interface alu_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_d_vld;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  out_valid;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [3:0]            alu_fun;
    logic                  alu_en;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_d_vld;
    logic                  alu_err;
    logic                  cmd_drop;

    modport master (
        output rx_p_data, rx_d_vld, alu_out, out_valid, fifo_full,
        input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, alu_err, cmd_drop
    );

    modport slave (
        input  rx_p_data, rx_d_vld, alu_out, out_valid, fifo_full,
        output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, alu_err, cmd_drop
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Parses CC/A/B/FUN or DD/FUN frames, runs the ALU with a bounded wait, forwards one result byte.
// FUN byte at n -> ALU_EN n+1 -> TX strobe >= n+2; a full TX FIFO stalls in SEND with the byte held.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPR  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOPR = 8'hDD,
    parameter int                    TIMEOUT     = 15,
    parameter logic [DATA_WIDTH-1:0] ERR_CODE    = 8'hEE
) (
    input logic          clk,
    input logic          rst,
    alu_cmd_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        GET_FUN  = 3'd3,
        WAIT_RES = 3'd4,
        SEND     = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [3:0]            alu_fun_q;
    logic [DATA_WIDTH-1:0] tx_dat_q;
    logic                  alu_err_q;
    logic                  cmd_drop_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  alu_en_c;
    logic                  tx_vld_c;

    logic is_opr;
    logic is_nopr;
    logic timeout_hit;

    assign is_opr      = (bus.rx_p_data == CMD_ALU_OPR);
    assign is_nopr     = (bus.rx_p_data == CMD_ALU_NOPR);
    // Last permitted wait cycle; a result arriving on this same cycle still wins.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rx_d_vld && is_opr) begin
                    state_nxt = GET_A;
                end else if (bus.rx_d_vld && is_nopr) begin
                    state_nxt = GET_FUN;
                end
            end
            GET_A:    if (bus.rx_d_vld) state_nxt = GET_B;
            GET_B:    if (bus.rx_d_vld) state_nxt = GET_FUN;
            GET_FUN:  if (bus.rx_d_vld) state_nxt = WAIT_RES;
            WAIT_RES: if (bus.out_valid || timeout_hit) state_nxt = SEND;
            SEND:     if (!bus.fifo_full) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_en_c = 1'b0;
        tx_vld_c = 1'b0;
        case (state)
            WAIT_RES: alu_en_c = 1'b1;
            SEND:     tx_vld_c = !bus.fifo_full;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            tx_dat_q   <= '0;
            alu_err_q  <= 1'b0;
            cmd_drop_q <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            alu_err_q  <= 1'b0;
            cmd_drop_q <= 1'b0;

            if (bus.rx_d_vld) begin
                case (state)
                    IDLE:    cmd_drop_q <= !(is_opr || is_nopr);
                    GET_A:   alu_a_q    <= bus.rx_p_data;
                    GET_B:   alu_b_q    <= bus.rx_p_data;
                    GET_FUN: alu_fun_q  <= bus.rx_p_data[3:0];
                    default: cmd_drop_q <= 1'b1;
                endcase
            end

            if (state == WAIT_RES) begin
                if (bus.out_valid) begin
                    tx_dat_q <= bus.alu_out;
                    wait_cnt <= '0;
                end else if (timeout_hit) begin
                    tx_dat_q  <= ERR_CODE;
                    alu_err_q <= 1'b1;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_fun   = alu_fun_q;
    assign bus.alu_en    = alu_en_c;
    assign bus.tx_p_data = tx_dat_q;
    assign bus.tx_d_vld  = tx_vld_c;
    assign bus.alu_err   = alu_err_q;
    assign bus.cmd_drop  = cmd_drop_q;
endmodule
